// File: rtl/julia_frame_engine.sv
// julia_frame_engine: multi-lane Julia renderer writing one 8-bit colour per pixel to a VGA buffer.
// Optional feature macro MANDEL_MODE_EN adds a mode input selecting Mandelbrot rendering.
module julia_frame_engine #(
  parameter int unsigned WIDTH      = 27,
  parameter int unsigned FRAC       = 23,
  parameter int unsigned ITER_W     = 10,
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned CLK_PER_MS = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] init_x,
  input  logic signed [WIDTH-1:0] init_y,
  input  logic signed [WIDTH-1:0] step,
  input  logic signed [WIDTH-1:0] c_re,
  input  logic signed [WIDTH-1:0] c_im,
  input  logic [ITER_W-1:0]       max_iter,
`ifdef MANDEL_MODE_EN
  input  logic                    mode,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             frame_ms,
  output logic [ADDR_W-1:0]       vga_address,
  output logic [7:0]              vga_writedata,
  output logic                    vga_write,
  output logic                    vga_chipselect,
  output logic                    vga_clken
);

  localparam int unsigned COL_W  = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned ROW_W  = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned SUB_W  = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int unsigned PW     = 2 * WIDTH + 2;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(V_RES - 1);
  localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(CLK_PER_MS - 1);
  localparam logic [PW-1:0]    FOUR     = PW'(4) << (2 * FRAC);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  state_e state_q, state_d;

  logic signed [WIDTH-1:0] x0_q, x_q, y_q, step_q, c_re_q, c_im_q;
  logic [ITER_W-1:0]       max_iter_q;
  logic [COL_W-1:0]        col_q;
  logic [ROW_W-1:0]        row_q;
  logic [ADDR_W-1:0]       pix_addr_q;
`ifdef MANDEL_MODE_EN
  logic                    mode_q;
`endif
  logic [SUB_W-1:0]        sub_q;
  logic [31:0]             ms_q;

  logic [NUM_LANES-1:0]    lane_idle, lane_fin;
  logic [ADDR_W-1:0]       lane_addr  [NUM_LANES];
  logic [7:0]              lane_color [NUM_LANES];
  logic                    disp_ok, gnt_ok, last_pix, accept;
  logic [LANE_W-1:0]       disp_idx, gnt_idx;

  assign accept   = (state_q == StIdle) && start;
  assign last_pix = (col_q == LAST_COL) && (row_q == LAST_ROW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (disp_ok && last_pix) state_d = StDrain;
      StDrain: if (&lane_idle) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // Frame parameters are captured at start; the raster walker advances once per dispatch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      step_q     <= '0;
      c_re_q     <= '0;
      c_im_q     <= '0;
      max_iter_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      pix_addr_q <= '0;
`ifdef MANDEL_MODE_EN
      mode_q     <= 1'b0;
`endif
    end else if (accept) begin
      x0_q       <= init_x;
      x_q        <= init_x;
      y_q        <= init_y;
      step_q     <= step;
      c_re_q     <= c_re;
      c_im_q     <= c_im;
      max_iter_q <= max_iter;
      col_q      <= '0;
      row_q      <= '0;
      pix_addr_q <= '0;
`ifdef MANDEL_MODE_EN
      mode_q     <= mode;
`endif
    end else if (disp_ok) begin
      pix_addr_q <= pix_addr_q + ADDR_W'(1);
      if (col_q == LAST_COL) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
        x_q   <= x0_q;
        y_q   <= y_q - step_q;
      end else begin
        col_q <= col_q + COL_W'(1);
        x_q   <= x_q + step_q;
      end
    end
  end

  // Lowest-index idle lane takes the next pixel; lowest-index finished lane gets the write port.
  always_comb begin
    disp_ok  = 1'b0;
    disp_idx = '0;
    gnt_ok   = 1'b0;
    gnt_idx  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_idle[i]) begin
        disp_ok  = 1'b1;
        disp_idx = LANE_W'(i);
      end
      if (lane_fin[i]) begin
        gnt_ok  = 1'b1;
        gnt_idx = LANE_W'(i);
      end
    end
    if (state_q != StRun) disp_ok = 1'b0;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic                      act_q, fin_q;
    logic signed [WIDTH-1:0]   zr_q, zi_q, cr_q, ci_q;
    logic [ITER_W-1:0]         n_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [7:0]                color_q;
    logic signed [2*WIDTH-1:0] zr_w, zi_w, zr2, zi2, zrzi;
    logic signed [PW-1:0]      cr_w, ci_w, nr, ni;
    logic [PW-1:0]             mag;
    logic [ITER_W:0]           n_inc;
    logic [7:0]                esc_color;
    logic                      esc, load, gnt;

    assign load = disp_ok && (disp_idx == LANE_W'(g));
    assign gnt  = gnt_ok && (gnt_idx == LANE_W'(g));

    // Products kept at full width so the escape test never overflows; new z wraps freely.
    always_comb begin
      zr_w      = {{WIDTH{zr_q[WIDTH-1]}}, zr_q};
      zi_w      = {{WIDTH{zi_q[WIDTH-1]}}, zi_q};
      zr2       = zr_w * zr_w;
      zi2       = zi_w * zi_w;
      zrzi      = zr_w * zi_w;
      cr_w      = {{(PW-WIDTH){cr_q[WIDTH-1]}}, cr_q} << FRAC;
      ci_w      = {{(PW-WIDTH){ci_q[WIDTH-1]}}, ci_q} << FRAC;
      mag       = {2'b00, zr2} + {2'b00, zi2};
      nr        = {{2{zr2[2*WIDTH-1]}}, zr2} - {{2{zi2[2*WIDTH-1]}}, zi2} + cr_w;
      ni        = {zrzi[2*WIDTH-1], zrzi, 1'b0} + ci_w;
      esc       = (mag > FOUR);
      n_inc     = {1'b0, n_q} + {{ITER_W{1'b0}}, 1'b1};
      esc_color = (n_inc > (ITER_W+1)'(255)) ? 8'hff : n_inc[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        act_q   <= 1'b0;
        fin_q   <= 1'b0;
        zr_q    <= '0;
        zi_q    <= '0;
        cr_q    <= '0;
        ci_q    <= '0;
        n_q     <= '0;
        addr_q  <= '0;
        color_q <= '0;
      end else if (load) begin
        act_q  <= 1'b1;
        n_q    <= '0;
        addr_q <= pix_addr_q;
`ifdef MANDEL_MODE_EN
        if (mode_q) begin
          zr_q <= '0;
          zi_q <= '0;
          cr_q <= x_q;
          ci_q <= y_q;
        end else begin
          zr_q <= x_q;
          zi_q <= y_q;
          cr_q <= c_re_q;
          ci_q <= c_im_q;
        end
`else
        zr_q <= x_q;
        zi_q <= y_q;
        cr_q <= c_re_q;
        ci_q <= c_im_q;
`endif
      end else if (act_q) begin
        if (esc) begin
          act_q   <= 1'b0;
          fin_q   <= 1'b1;
          color_q <= esc_color;
        end else if (n_q == max_iter_q) begin
          act_q   <= 1'b0;
          fin_q   <= 1'b1;
          color_q <= 8'h00;
        end else begin
          zr_q <= nr[FRAC+WIDTH-1:FRAC];
          zi_q <= ni[FRAC+WIDTH-1:FRAC];
          n_q  <= n_inc[ITER_W-1:0];
        end
      end else if (gnt) begin
        fin_q <= 1'b0;
      end
    end

    assign lane_idle[g]  = ~act_q & ~fin_q;
    assign lane_fin[g]   = fin_q;
    assign lane_addr[g]  = addr_q;
    assign lane_color[g] = color_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_write     <= 1'b0;
      vga_address   <= '0;
      vga_writedata <= '0;
    end else begin
      vga_write <= gnt_ok;
      if (gnt_ok) begin
        vga_address   <= lane_addr[gnt_idx];
        vga_writedata <= lane_color[gnt_idx];
      end
    end
  end

  assign vga_chipselect = vga_write;
  assign vga_clken      = ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_q    <= '0;
      ms_q     <= '0;
      frame_ms <= '0;
    end else if (accept) begin
      sub_q <= '0;
      ms_q  <= '0;
    end else if (busy) begin
      if (sub_q == LAST_SUB) begin
        sub_q <= '0;
        if (ms_q != 32'hffff_ffff) ms_q <= ms_q + 32'd1;
      end else begin
        sub_q <= sub_q + SUB_W'(1);
      end
      if (state_q == StDone) frame_ms <= ms_q;
    end
  end

endmodule
